door_input_cond: RTL and testbench

//  Input conditioner directly upstream of the door motor controller. Synchronises and

---
 rtl/door_input_cond.sv | 107 ++++++++++
 tb/tb_door_input_cond.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/door_input_cond.sv
// door_input_cond: synchronises and debounces the door button and limit switches, emits a rate-limited activate pulse.
// Optional DOOR_COND_REMOTE_EN adds a remote_raw button channel sharing the lockout.
module door_input_cond #(
  parameter int SYNC_STAGES    = 2,
  parameter int DB_CYCLES      = 16,
  parameter int DB_W           = 5,
  parameter int LOCKOUT_CYCLES = 32,
  parameter int LOCK_W         = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic up_sw_raw,
  input  logic dn_sw_raw,
`ifdef DOOR_COND_REMOTE_EN
  input  logic remote_raw,
`endif
  output logic activate,
  output logic up_limit,
  output logic dn_limit,
  output logic limit_fault
);
`ifdef DOOR_COND_REMOTE_EN
  localparam int NCH = 4;
  localparam int NP = 2;
  localparam logic [NCH-1:0] DB_RST = 4'b1001;
  logic [NCH-1:0] raw;
  logic [NP-1:0] press;
  assign raw = {remote_raw, dn_sw_raw, up_sw_raw, btn_raw};
`else
  localparam int NCH = 3;
  localparam int NP = 1;
  localparam logic [NCH-1:0] DB_RST = 3'b001;
  logic [NCH-1:0] raw;
  logic [NP-1:0] press;
  assign raw = {dn_sw_raw, up_sw_raw, btn_raw};
`endif
  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, LOCK = 2'd2} state_t;
  logic [NCH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NCH-1:0][DB_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0] s, db_q, db_d;
  logic [NP-1:0] prs_q, prs_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  state_t state_q, state_d;
  logic activate_q, activate_d, up_limit_q, up_limit_d, dn_limit_q, dn_limit_d;
  logic limit_fault_q, limit_fault_d, rise;
  always_comb begin
    sync_d = '0;
    cnt_d = '0;
    s = '0;
    db_d = '0;
    for (int i = 0; i < NCH; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      s[i] = sync_q[i][SYNC_STAGES-1];
      db_d[i] = (s[i] != db_q[i] && cnt_q[i] == DB_W'(DB_CYCLES - 1)) ? s[i] : db_q[i];
      cnt_d[i] = (s[i] == db_q[i] || cnt_q[i] == DB_W'(DB_CYCLES - 1)) ? '0 : cnt_q[i] + 1'b1;
    end
  end
`ifdef DOOR_COND_REMOTE_EN
  assign press = {db_q[3], db_q[0]};
`else
  assign press = db_q[0];
`endif
  // simultaneous rises on several press channels collapse into one request
  assign rise = |(press & ~prs_q);
  always_comb begin
    prs_d = press;
    state_d = (state_q == IDLE)  ? ((rise && !limit_fault_q) ? PULSE : IDLE) :
              (state_q == PULSE) ? LOCK :
              (state_q == LOCK)  ? ((lock_cnt_q == '0) ? IDLE : LOCK) : IDLE;
    lock_cnt_d = (state_q == PULSE) ? LOCK_W'(LOCKOUT_CYCLES - 1) :
                 (state_q == LOCK && lock_cnt_q != '0) ? lock_cnt_q - 1'b1 : lock_cnt_q;
    activate_d = (state_q == PULSE);
    up_limit_d = db_d[1];
    dn_limit_d = db_d[2];
    limit_fault_d = db_d[1] & db_d[2];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      db_q <= DB_RST;
      prs_q <= '1;
      lock_cnt_q <= '0;
      state_q <= IDLE;
      activate_q <= 1'b0;
      up_limit_q <= 1'b0;
      dn_limit_q <= 1'b0;
      limit_fault_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      db_q <= db_d;
      prs_q <= prs_d;
      lock_cnt_q <= lock_cnt_d;
      state_q <= state_d;
      activate_q <= activate_d;
      up_limit_q <= up_limit_d;
      dn_limit_q <= dn_limit_d;
      limit_fault_q <= limit_fault_d;
    end
  end
  assign activate = activate_q;
  assign up_limit = up_limit_q;
  assign dn_limit = dn_limit_q;
  assign limit_fault = limit_fault_q;
endmodule

// File: tb/tb_door_input_cond.sv
// tb_door_input_cond: directed checks of debounce latency, lockout, fault gating and reset behaviour.
module tb_door_input_cond;
  logic clk = 1'b0, rst = 1'b1, btn_raw = 1'b0, up_sw_raw = 1'b0, dn_sw_raw = 1'b0, remote_raw = 1'b0;
  logic activate, up_limit, dn_limit, limit_fault;
  logic prev_act = 1'b0;
  int total = 0, bad = 0;
  int cyc = 0, act_cnt = 0, last_act = -1, viol = 0;
  int c0, a0;
  always #5 clk = ~clk;
  door_input_cond dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .up_sw_raw(up_sw_raw),
    .dn_sw_raw(dn_sw_raw),
`ifdef DOOR_COND_REMOTE_EN
    .remote_raw(remote_raw),
`endif
    .activate(activate),
    .up_limit(up_limit),
    .dn_limit(dn_limit),
    .limit_fault(limit_fault)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (activate) begin
      act_cnt <= act_cnt + 1;
      last_act <= cyc;
    end
    if ((activate && prev_act) || (activate && limit_fault)) viol <= viol + 1;
    prev_act <= activate;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; btn_raw = 1'b0;
    tick(5);
    total++; if (activate !== 1'b0) begin bad++; $display("FAIL reset_activate got=%b exp=0", activate); end
    total++; if (up_limit !== 1'b0) begin bad++; $display("FAIL reset_up_limit got=%b exp=0", up_limit); end
    total++; if (dn_limit !== 1'b0) begin bad++; $display("FAIL reset_dn_limit got=%b exp=0", dn_limit); end
    total++; if (limit_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", limit_fault); end
    rst = 1'b0; btn_raw = 1'b1;
    tick(10);
    total++; if (act_cnt !== 0) begin bad++; $display("FAIL reset_no_pulse got=%0d exp=0", act_cnt); end
    btn_raw = 1'b0;
    tick(20);
    total++; if (act_cnt !== 0) begin bad++; $display("FAIL release_no_pulse got=%0d exp=0", act_cnt); end
  endtask
  task automatic test_press;
    c0 = cyc; a0 = act_cnt; btn_raw = 1'b1;
    tick(60);
    total++; if (act_cnt !== a0 + 1) begin bad++; $display("FAIL press_count got=%0d exp=%0d", act_cnt, a0 + 1); end
    total++; if (last_act - c0 !== 20) begin bad++; $display("FAIL press_latency got=%0d exp=20", last_act - c0); end
    btn_raw = 1'b0;
    tick(20);
  endtask
  task automatic test_lockout;
    c0 = cyc; a0 = act_cnt;
    btn_raw = 1'b1; tick(16);
    btn_raw = 1'b0; tick(16);
    btn_raw = 1'b1; tick(16);
    btn_raw = 1'b0; tick(40);
    total++; if (act_cnt !== a0 + 1) begin bad++; $display("FAIL lockout_drop got=%0d exp=%0d", act_cnt, a0 + 1); end
    total++; if (last_act - c0 !== 20) begin bad++; $display("FAIL lockout_first_lat got=%0d exp=20", last_act - c0); end
    c0 = cyc; btn_raw = 1'b1;
    tick(30);
    total++; if (act_cnt !== a0 + 2) begin bad++; $display("FAIL after_lockout got=%0d exp=%0d", act_cnt, a0 + 2); end
    total++; if (last_act - c0 !== 20) begin bad++; $display("FAIL after_lockout_lat got=%0d exp=20", last_act - c0); end
    btn_raw = 1'b0;
    tick(20);
  endtask
  task automatic test_glitch;
    a0 = act_cnt;
    btn_raw = 1'b1; tick(15);
    btn_raw = 1'b0; tick(30);
    total++; if (act_cnt !== a0) begin bad++; $display("FAIL glitch15 got=%0d exp=%0d", act_cnt, a0); end
    c0 = cyc;
    btn_raw = 1'b1; tick(16);
    btn_raw = 1'b0; tick(30);
    total++; if (act_cnt !== a0 + 1) begin bad++; $display("FAIL press16 got=%0d exp=%0d", act_cnt, a0 + 1); end
    total++; if (last_act - c0 !== 20) begin bad++; $display("FAIL press16_lat got=%0d exp=20", last_act - c0); end
  endtask
  task automatic test_fault;
    tick(20);
    up_sw_raw = 1'b1; dn_sw_raw = 1'b1;
    tick(17);
    total++; if (limit_fault !== 1'b0) begin bad++; $display("FAIL fault_early got=%b exp=0", limit_fault); end
    tick(1);
    total++; if (limit_fault !== 1'b1) begin bad++; $display("FAIL fault_set got=%b exp=1", limit_fault); end
    total++; if (up_limit !== 1'b1) begin bad++; $display("FAIL up_set got=%b exp=1", up_limit); end
    total++; if (dn_limit !== 1'b1) begin bad++; $display("FAIL dn_set got=%b exp=1", dn_limit); end
    a0 = act_cnt; btn_raw = 1'b1;
    tick(40);
    btn_raw = 1'b0;
    tick(20);
    total++; if (act_cnt !== a0) begin bad++; $display("FAIL fault_blocks got=%0d exp=%0d", act_cnt, a0); end
    dn_sw_raw = 1'b0;
    tick(17);
    total++; if (limit_fault !== 1'b1) begin bad++; $display("FAIL fault_hold got=%b exp=1", limit_fault); end
    tick(1);
    total++; if (limit_fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", limit_fault); end
    total++; if (dn_limit !== 1'b0) begin bad++; $display("FAIL dn_clear got=%b exp=0", dn_limit); end
    total++; if (up_limit !== 1'b1) begin bad++; $display("FAIL up_hold got=%b exp=1", up_limit); end
    c0 = cyc; btn_raw = 1'b1;
    tick(30);
    total++; if (act_cnt !== a0 + 1) begin bad++; $display("FAIL up_only_press got=%0d exp=%0d", act_cnt, a0 + 1); end
    total++; if (last_act - c0 !== 20) begin bad++; $display("FAIL up_only_lat got=%0d exp=20", last_act - c0); end
    btn_raw = 1'b0; up_sw_raw = 1'b0;
    tick(20);
  endtask
  task automatic test_midrst;
    tick(40);
    a0 = act_cnt; btn_raw = 1'b1;
    tick(19);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total++; if (activate !== 1'b0) begin bad++; $display("FAIL midrst_activate got=%b exp=0", activate); end
    tick(40);
    total++; if (act_cnt !== a0) begin bad++; $display("FAIL midrst_no_pulse got=%0d exp=%0d", act_cnt, a0); end
  endtask
  task automatic test_rst_held;
    rst = 1'b1; btn_raw = 1'b1;
    tick(5);
    rst = 1'b0;
    a0 = act_cnt;
    tick(40);
    total++; if (act_cnt !== a0) begin bad++; $display("FAIL held_rst_no_pulse got=%0d exp=%0d", act_cnt, a0); end
    btn_raw = 1'b0;
    tick(20);
    c0 = cyc; btn_raw = 1'b1;
    tick(30);
    total++; if (act_cnt !== a0 + 1) begin bad++; $display("FAIL held_rst_repress got=%0d exp=%0d", act_cnt, a0 + 1); end
    total++; if (last_act - c0 !== 20) begin bad++; $display("FAIL held_rst_lat got=%0d exp=20", last_act - c0); end
    btn_raw = 1'b0;
    tick(20);
  endtask
`ifdef DOOR_COND_REMOTE_EN
  task automatic test_remote;
    tick(40);
    a0 = act_cnt; c0 = cyc;
    btn_raw = 1'b1; remote_raw = 1'b1;
    tick(40);
    total++; if (act_cnt !== a0 + 1) begin bad++; $display("FAIL both_rise got=%0d exp=%0d", act_cnt, a0 + 1); end
    btn_raw = 1'b0; remote_raw = 1'b0;
    tick(40);
    c0 = cyc; remote_raw = 1'b1;
    tick(30);
    total++; if (act_cnt !== a0 + 2) begin bad++; $display("FAIL remote_only got=%0d exp=%0d", act_cnt, a0 + 2); end
    total++; if (last_act - c0 !== 20) begin bad++; $display("FAIL remote_lat got=%0d exp=20", last_act - c0); end
    remote_raw = 1'b0;
    tick(20);
  endtask
`endif
  initial begin
    test_reset;
    test_press;
    test_lockout;
    test_glitch;
    test_fault;
    test_midrst;
    test_rst_held;
`ifdef DOOR_COND_REMOTE_EN
    test_remote;
`endif
    total++; if (viol !== 0) begin bad++; $display("FAIL monitor_violations got=%0d exp=0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
